// File: rtl/handshake_rr_arbiter.sv
// Round-robin, packet-locked arbiter that merges N valid/ready requester channels
// into one registered valid/ready output stage with a per-grant beat limit.
module handshake_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int IDW       = 2,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      s_valid,
  input  logic [N*DW-1:0]   s_data,
  input  logic [N-1:0]      s_last,
  output logic [N-1:0]      s_ready,
  output logic              m_valid,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  output logic [IDW-1:0]    m_id,
  input  logic              m_ready,
  output logic              err_timeout
);

  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  last_ptr;
  logic [IDW-1:0]  pick;
  logic [CW-1:0]   beat_cnt;
  logic [DW-1:0]   s_data_arr [N];
  logic            found;
  logic            load_en;
  logic            in_xfer;
  logic            at_limit;

  always_comb begin
    for (int i = 0; i < N; i++) s_data_arr[i] = s_data[i*DW +: DW];
  end

  // The output register may accept a new beat when it is empty or draining this cycle.
  assign load_en  = ~m_valid | m_ready;
  assign in_xfer  = (state == LOCKED) & s_valid[gnt] & load_en;
  assign at_limit = (beat_cnt == CW'(MAX_BEATS - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    s_ready = '0;
    if (state == LOCKED) s_ready[gnt] = load_en;
  end

  // Scan from the requester after the last owner, wrapping, so the last owner has lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && s_valid[(int'(last_ptr) + k) % N]) begin
        pick  = IDW'((int'(last_ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      last_ptr    <= IDW'(N - 1);
      beat_cnt    <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      m_id        <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;

      if (in_xfer) begin
        m_valid <= 1'b1;
        m_data  <= s_data_arr[gnt];
        m_last  <= s_last[gnt] | at_limit;
        m_id    <= gnt;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (found) begin
            gnt      <= pick;
            beat_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (in_xfer) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (s_last[gnt] | at_limit) begin
              last_ptr    <= gnt;
              state       <= IDLE;
              err_timeout <= ~s_last[gnt];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Randomized bench for handshake_rr_arbiter: a transaction-level model predicts grants,
// ready, output beats and timeouts; a monitor pops the scoreboard on each output transfer.
module tb_handshake_rr_arbiter;
  localparam int N = 4, DW = 32, IDW = 2, MAX_BEATS = 16;

  logic            clk, rst;
  logic [N-1:0]    s_valid, s_last, s_ready;
  logic [N*DW-1:0] s_data;
  logic            m_valid, m_last, m_ready, err_timeout;
  logic [DW-1:0]   m_data;
  logic [IDW-1:0]  m_id;

  handshake_rr_arbiter #(.N(N), .DW(DW), .IDW(IDW), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_id(m_id), .m_ready(m_ready), .err_timeout(err_timeout)
  );

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [DW-1:0] data; logic [IDW-1:0] id; logic last;} exp_t;

  beat_t          src [N][$];
  exp_t           sb [$];
  logic [IDW-1:0] obs_ids [$];
  int             n_checks = 0, n_pass = 0, tmo_seen = 0;
  int             vpct [N];
  int             rpct;

  // Model state: whether a grant is held, by whom, beats sent in it, and the previous owner.
  bit   locked;
  int   owner, cnt, last_ptr;
  logic exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit busy();
    busy = (sb.size() != 0);
    for (int i = 0; i < N; i++) if (src[i].size() != 0) busy = 1'b1;
  endfunction

  task automatic push_pkt(input int req, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + DW'(k);
      b.last = (k == len - 1);
      src[req].push_back(b);
    end
  endtask

  // One cycle of the reference model, evaluated with inputs stable before the next rising edge.
  task automatic model_step();
    bit         mv, load, xfer, tmo, is_last;
    logic [N-1:0] exp_ready;
    beat_t      b;
    exp_t       e;
    mv   = (sb.size() != 0);
    load = !mv || m_ready;
    exp_ready = '0;
    if (locked && load) exp_ready[owner] = 1'b1;
    check("m_valid", m_valid, mv);
    check("err_timeout", err_timeout, exp_err);
    check("s_ready", s_ready, exp_ready);
    xfer = locked && s_valid[owner] && load;
    tmo  = 1'b0;
    if (xfer) begin
      b = src[owner].pop_front();
      cnt++;
      is_last = b.last || (cnt == MAX_BEATS);
      e.data = b.data;
      e.id   = IDW'(owner);
      e.last = is_last;
      sb.push_back(e);
      if (is_last) begin
        locked   = 1'b0;
        last_ptr = owner;
        tmo      = !b.last;
      end
    end else if (!locked && s_valid != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (s_valid[(last_ptr + k) % N]) begin
          owner = (last_ptr + k) % N;
          break;
        end
      end
      locked = 1'b1;
      cnt    = 0;
    end
    exp_err = tmo;
  endtask

  // Stimulus driver plus model: drive on the falling edge, evaluate 1 time unit later.
  initial begin
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0;
    locked = 1'b0; owner = 0; cnt = 0; last_ptr = N - 1; exp_err = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (src[i].size() != 0 && int'($urandom_range(99)) < vpct[i]) begin
          s_valid[i]          = 1'b1;
          s_data[i*DW +: DW]  = src[i][0].data;
          s_last[i]           = src[i][0].last;
        end else begin
          s_valid[i]          = 1'b0;
          s_data[i*DW +: DW]  = $urandom;
          s_last[i]           = 1'($urandom_range(1));
        end
      end
      m_ready = (int'($urandom_range(99)) < rpct);
      #1;
      if (rst) begin
        locked = 1'b0; owner = 0; cnt = 0; last_ptr = N - 1; exp_err = 1'b0;
        sb.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compare each output transfer against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (err_timeout) tmo_seen++;
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", m_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            check("m_data", m_data, e.data);
            check("m_id", m_id, e.id);
            check("m_last", m_last, e.last);
            obs_ids.push_back(m_id);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (busy() && k < budget) begin
      @(posedge clk);
      k++;
    end
    #3;
    check("drain", busy(), 1'b0);
  endtask

  initial begin
    int t0;
    rst  = 1'b1;
    rpct = 100;
    for (int i = 0; i < N; i++) vpct[i] = 100;
    cycles(2);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_id", m_id, '0);
    check("rst_s_ready", s_ready, '0);
    check("rst_err_timeout", err_timeout, 1'b0);
    rst = 1'b0;

    // All four requesters with single-beat packets; requester 0 has two.
    obs_ids.delete();
    push_pkt(0, 1, 32'hB0);
    push_pkt(1, 1, 32'hB1);
    push_pkt(2, 1, 32'hB2);
    push_pkt(3, 1, 32'hB3);
    push_pkt(0, 1, 32'hB4);
    wait_drain(100);
    check("order_len", obs_ids.size(), 5);
    check("order_0", obs_ids[0], 0);
    check("order_1", obs_ids[1], 1);
    check("order_2", obs_ids[2], 2);
    check("order_3", obs_ids[3], 3);
    check("order_4", obs_ids[4], 0);

    // Single requester, 3-beat packet.
    push_pkt(0, 3, 32'hA0);
    wait_drain(50);

    // Back-pressure on requester 2 mid-packet.
    push_pkt(2, 4, 32'hC0);
    cycles(3);
    rpct = 0;
    cycles(3);
    rpct = 100;
    wait_drain(100);

    // Beat-limit timeout on requester 1, requester 3 waiting.
    obs_ids.delete();
    t0 = tmo_seen;
    push_pkt(1, 20, 32'hD0);
    cycles(3);
    push_pkt(3, 2, 32'hE0);
    wait_drain(200);
    check("timeout_pulses", tmo_seen - t0, 1);
    check("post_timeout_winner", obs_ids[16], 3);
    check("post_timeout_last", obs_ids[18], 1);

    // Asynchronous reset while a beat is presented.
    push_pkt(0, 8, 32'hF0);
    push_pkt(2, 6, 32'hF8);
    cycles(4);
    check("pre_rst_m_valid", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_m_valid", m_valid, 1'b0);
    check("async_rst_s_ready", s_ready, '0);
    check("async_rst_err", err_timeout, 1'b0);
    obs_ids.delete();
    cycles(2);
    rst = 1'b0;
    wait_drain(200);
    check("post_rst_first_id", obs_ids[0], 0);

    // Granted requester 0 stalls its valid while requester 1 waits.
    t0 = tmo_seen;
    push_pkt(0, 6, 32'h100);
    cycles(2);
    push_pkt(1, 2, 32'h110);
    vpct[0] = 0;
    cycles(5);
    vpct[0] = 100;
    wait_drain(100);
    check("stall_no_timeout", tmo_seen - t0, 0);

    // Randomized traffic with varying valid and ready rates.
    for (int p = 0; p < 250; p++) begin
      if (p % 25 == 0) begin
        for (int i = 0; i < N; i++) vpct[i] = int'($urandom_range(30, 100));
        rpct = int'($urandom_range(40, 100));
      end
      push_pkt(int'($urandom_range(N - 1)), int'($urandom_range(1, 20)), $urandom);
      cycles(int'($urandom_range(0, 8)));
    end
    wait_drain(30000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one valid/ready handshake pipe between N master-side requester channels.
- Sits between several master_interface instances and the single handshake pipe feeding slave_interface.
- Output is one registered ("valid patted") stage with full throughput; a grant holds until the owner's last beat or a beat-limit timeout.

Parameters:
- N, 4, number of requester channels (2..8)
- DW, 32, data width per beat
- IDW, 2, width of m_id; must equal ceil(log2(N))
- MAX_BEATS, 16, beat limit per grant before forced release (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- s_valid  in  N  per-requester beat valid
- s_data  in  N*DW  per-requester data; requester i occupies bits [i*DW +: DW]
- s_last  in  N  per-requester last beat of packet
- s_ready  out  N  per-requester ready; at most one bit high
- m_valid  out  1  output beat valid
- m_data  out  DW  output beat data
- m_last  out  1  output last flag; forced 1 on a timeout beat
- m_id  out  IDW  index of the requester that produced the output beat
- m_ready  in  1  downstream ready
- err_timeout  out  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (asynchronous, active-high):
  - m_valid=0, m_data=0, m_last=0, m_id=0, s_ready=0, err_timeout=0.
  - state=IDLE, gnt=0, beat_cnt=0, last_ptr=N-1, so requester 0 has first priority.
- Reset mid-packet drops the in-flight beat and the grant with no completion.
- Transfer definitions:
  - Input transfer: s_valid[gnt] & s_ready[gnt].
  - Output transfer: m_valid & m_ready.
- load_en = ~m_valid | m_ready.
- FSM IDLE:
  - s_ready=0.
  - If any s_valid is high, pick the first requester scanning (last_ptr+1) mod N upward with wrap.
  - Register it into gnt, clear beat_cnt, go to LOCKED.
  - No beat moves in the arbitration cycle: a 1-cycle bubble per packet.
- FSM LOCKED:
  - s_ready[gnt]=load_en; all other s_ready bits are 0.
  - On input transfer: m_data<=s_data[gnt], m_id<=gnt, m_valid<=1, beat_cnt++.
  - m_last<=s_last[gnt] | (beat_cnt==MAX_BEATS-1).
  - If that beat has s_last=1: last_ptr<=gnt, go to IDLE.
  - Else if beat_cnt==MAX_BEATS-1: last_ptr<=gnt, err_timeout pulses 1 cycle, go to IDLE. The requester continues its packet as a new packet after re-arbitration.
  - s_valid[gnt] dropping mid-packet: grant is held, no beats move, no timeout accrues (the count is beats, not cycles).
- Output register:
  - If m_ready & ~(input transfer): m_valid<=0.
  - While m_valid & ~m_ready: m_data, m_last and m_id hold stable.
  - Simultaneous output and input transfer: new beat replaces old, m_valid stays 1, giving 1 beat/cycle throughput.
- Latency: s-side accept to m_valid is 1 cycle. The LOCKED to IDLE to LOCKED packet turnaround costs exactly one idle cycle on the s side.
- Fairness: a requester that just finished cannot win again while any other requester is valid at the arbitration cycle.
- Single requester: re-wins every arbitration cycle.
- s_valid of non-granted requesters is ignored; their data need not be stable.
- s_data and s_last of the granted requester are sampled only on an input transfer.

Test Plan:
- Reset, then s_valid=4'b0001, 3-beat packet 0xA0,0xA1,0xA2 with last on beat 3, m_ready=1. Required: IDLE one cycle; m_valid high 3 consecutive cycles with m_id=0; m_last only on 0xA2; then s_ready=0 for 1 cycle.
- All four requesters valid, each with single-beat packets, m_ready=1. Required: m_id order 0,1,2,3,0 with exactly one bubble between beats.
- Requester 2 mid-packet with m_ready low for 3 cycles. Required: m_data/m_last/m_id frozen, s_ready[2]=0 while m_valid=1. On m_ready high, the beat drains and the next beat loads in the same cycle.
- Requester 1 streams 20 beats with no last, MAX_BEATS=16. Required: beat 16 has m_last=1 and err_timeout pulses once. If requester 3 is also valid it wins next; the remaining 4 beats follow after it.
- Assert rst while LOCKED with m_valid=1. Required: m_valid, s_ready and err_timeout go 0 asynchronously. After release the first grant goes to the lowest valid requester.
- Granted requester 0 deasserts s_valid for 5 cycles mid-packet while requester 1 is valid. Required: s_ready[1] stays 0, no m_valid, no timeout; the packet resumes when s_valid[0] returns.
